adc_sequencer: RTL and testbench

Sample scheduler between the CPU register interface and the SPI SAR ADC core. It issues single-shot or periodic conversion starts from a programmable sample timer. It handles abort and disable, and buffers 12-bit results in a small first-word-fall-through FIFO that the CPU drains. This block is the sole driver of the ADC core's start and abort inputs.

---
 rtl/adc_sequencer_if.sv | 15 +
 rtl/adc_sequencer.sv | 149 ++++++++++++++
 tb/tb_adc_sequencer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_sequencer_if.sv
// adc_sequencer_if: link between the sample sequencer and the SPI SAR ADC core.
//   master (sequencer side): drives adc_start, adc_abort; samples adc_busy, adc_done, adc_data
//   slave  (ADC core side) : the mirror image
interface adc_sequencer_if #(
  parameter int DATA_W = 12
);
  logic              adc_start;  // one-cycle conversion start
  logic              adc_abort;  // one-cycle abort
  logic              adc_busy;   // conversion in progress
  logic              adc_done;   // one-cycle result strobe
  logic [DATA_W-1:0] adc_data;   // result, valid with adc_done

  modport master (output adc_start, adc_abort, input adc_busy, adc_done, adc_data);
  modport slave  (input adc_start, adc_abort, output adc_busy, adc_done, adc_data);
endinterface

// File: rtl/adc_sequencer.sv
// adc_sequencer: schedules single-shot or periodic ADC conversions from a sample
// timer, handles abort/disable, and buffers results in a small FWFT FIFO.
//   clk, reset       : system clock, synchronous active-high reset
//   cfg_enable       : enable; a falling edge while active aborts
//   cfg_mode         : 0 single shot, 1 periodic
//   cfg_period       : start-to-start period in clocks (values below 2 act as 2)
//   cmd_start/abort  : one-cycle CPU commands
//   clr_overrun      : clears the sticky overrun flag
//   adc              : sequencer side of the ADC core link (start/abort out, busy/done/data in)
//   rd_en / rd_data  : FIFO pop and head (0 when empty)
//   fifo_count, busy, overrun, irq : status
module adc_sequencer #(
  parameter int DATA_W     = 12,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_enable,
  input  logic                         cfg_mode,
  input  logic [DIV_W-1:0]             cfg_period,
  input  logic                         cmd_start,
  input  logic                         cmd_abort,
  input  logic                         clr_overrun,
  adc_sequencer_if.master              adc,
  input  logic                         rd_en,
  output logic [DATA_W-1:0]            rd_data,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         busy,
  output logic                         overrun,
  output logic                         irq
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_CONV, S_WAIT, S_DRAIN} state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_timer;
  logic             r_pending;
  logic             r_en_d;
  logic             r_adc_start;
  logic             r_adc_abort;

  logic             w_active;
  logic             w_abort;
  logic             w_due;
  logic             w_push;
  logic [DIV_W-1:0] w_reload;

  assign w_active = (r_state == S_START) || (r_state == S_CONV) || (r_state == S_WAIT);
  assign w_abort  = w_active && (cmd_abort || (r_en_d && !cfg_enable));
  // Timer at 1 means it hits 0 on this edge; the next start belongs in the
  // following cycle so start-to-start is exactly P.
  assign w_due    = (r_timer <= DIV_W'(1));
  assign w_reload = (cfg_period < DIV_W'(2)) ? DIV_W'(1) : cfg_period - DIV_W'(1);
  assign w_push   = (r_state == S_CONV) && adc.adc_done && !w_abort;

  assign adc.adc_start = r_adc_start;
  assign adc.adc_abort = r_adc_abort;
  assign busy          = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_pending   <= 1'b0;
      r_en_d      <= 1'b0;
      r_adc_start <= 1'b0;
      r_adc_abort <= 1'b0;
    end else begin
      r_en_d      <= cfg_enable;
      r_adc_start <= 1'b0;
      r_adc_abort <= 1'b0;
      if ((r_state == S_CONV || r_state == S_WAIT) && r_timer != '0)
        r_timer <= r_timer - DIV_W'(1);
      if (w_abort) begin
        r_state     <= S_DRAIN;
        r_pending   <= 1'b0;
        r_adc_abort <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: if (cmd_start && cfg_enable) begin
            r_state     <= S_START;
            r_adc_start <= 1'b1;
          end
          S_START: begin
            r_state <= S_CONV;
            if (cfg_mode) r_timer <= w_reload;
          end
          S_CONV: if (adc.adc_done) begin
            r_pending <= 1'b0;
            if (!cfg_mode) r_state <= S_IDLE;
            else if (r_pending || w_due) begin
              // period already elapsed: restart immediately, never queue more
              r_state     <= S_START;
              r_adc_start <= 1'b1;
            end else r_state <= S_WAIT;
          end else if (w_due) r_pending <= 1'b1;
          S_WAIT: if (w_due) begin
            r_state     <= S_START;
            r_adc_start <= 1'b1;
          end
          S_DRAIN: if (!adc.adc_busy) r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // result FIFO, first-word-fall-through
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overrun;
  logic              w_full;
  logic              w_pop;
  logic              w_wr;

  assign w_full = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop  = rd_en && (r_count != '0);
  // a pop frees the slot on the same edge, so a full FIFO still accepts the push
  assign w_wr   = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= adc.adc_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CNT_W'(w_wr) - CNT_W'(w_pop);
      if (w_push && w_full && !w_pop) r_overrun <= 1'b1;
      else if (clr_overrun)           r_overrun <= 1'b0;
    end
  end

  assign rd_data    = (r_count != '0) ? r_mem[r_rptr] : '0;
  assign fifo_count = r_count;
  assign overrun    = r_overrun;
  assign irq        = (r_count != '0);
endmodule

// File: tb/tb_adc_sequencer.sv
module tb_adc_sequencer;
  localparam int DATA_W = 12;
  localparam int DIV_W  = 16;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cfg_enable = 1'b0;
  logic              cfg_mode = 1'b0;
  logic [DIV_W-1:0]  cfg_period = '0;
  logic              cmd_start = 1'b0;
  logic              cmd_abort = 1'b0;
  logic              clr_overrun = 1'b0;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic [2:0]        fifo_count;
  logic              busy, overrun, irq;

  adc_sequencer_if #(.DATA_W(DATA_W)) aif();

  adc_sequencer #(.DATA_W(DATA_W), .DIV_W(DIV_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .cfg_enable(cfg_enable), .cfg_mode(cfg_mode),
    .cfg_period(cfg_period), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .clr_overrun(clr_overrun), .adc(aif), .rd_en(rd_en), .rd_data(rd_data),
    .fifo_count(fifo_count), .busy(busy), .overrun(overrun), .irq(irq));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic cmp(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (event times, not timer states) ----------------
  int  cyc = 0;
  int  m_due = 0;          // absolute cycle of the next periodic start
  bit  m_run, m_drain, m_conv, m_en_d, m_ovr, e_start, e_abort, mdl_valid;
  bit  m_ab, m_ns, m_na, m_push, m_pop;
  int  q[$];

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      q.delete();
      {m_run, m_drain, m_conv, m_en_d, m_ovr, e_start, e_abort} = '0;
      mdl_valid = 1'b1;
    end else begin
      m_ab = cmd_abort || (m_en_d && !cfg_enable);
      m_en_d = cfg_enable;
      m_ns = 0; m_na = 0; m_push = 0;
      if (m_drain) begin
        if (!aif.adc_busy) m_drain = 0;
      end else if (m_run) begin
        if (m_ab) begin
          m_run = 0; m_conv = 0; m_drain = 1; m_na = 1;
        end else if (e_start) begin
          m_conv = 1;
          m_due = (cyc - 1) + ((int'(cfg_period) < 2) ? 2 : int'(cfg_period));
        end else if (m_conv) begin
          if (aif.adc_done) begin
            m_push = 1; m_conv = 0;
            if (!cfg_mode) m_run = 0;
            else if (m_due <= cyc) m_ns = 1;
          end
        end else if (cyc == m_due) m_ns = 1;
      end else if (cmd_start && cfg_enable) begin
        m_run = 1; m_ns = 1;
      end
      m_pop = rd_en && q.size() > 0;
      if (m_pop) void'(q.pop_front());
      if (m_push && q.size() == DEPTH) m_ovr = 1;
      else begin
        if (m_push) q.push_back(int'(aif.adc_data));
        if (clr_overrun) m_ovr = 0;
      end
      e_start = m_ns;
      e_abort = m_na;
    end
  end

  always @(negedge clk) begin
    if (mdl_valid) begin
      cmp("adc_start",  aif.adc_start, e_start);
      cmp("adc_abort",  aif.adc_abort, e_abort);
      cmp("busy",       busy, m_run || m_drain);
      cmp("fifo_count", fifo_count, q.size());
      cmp("rd_data",    rd_data, (q.size() > 0) ? q[0] : 0);
      cmp("irq",        irq, q.size() != 0);
      cmp("overrun",    overrun, m_ovr);
    end
  end

  // ---------------- ADC core stub and stepping ----------------
  int conv_len = 10, drain_len = 1;
  bit done_in_drain = 0, pend_dd = 0;
  int conv_left = 0, drain_left = 0;
  int data_q[$];
  int ncyc = 0, n_starts = 0, n_aborts = 0;
  int start_t[$], done_t[$];

  task automatic step();
    @(negedge clk);
    ncyc++;
    cmd_start = 0; cmd_abort = 0; clr_overrun = 0; rd_en = 0;
    aif.adc_done = 0;
    if (aif.adc_start) begin n_starts++; start_t.push_back(ncyc); end
    if (aif.adc_abort) n_aborts++;
    if (aif.adc_abort) begin
      conv_left = 0; drain_left = drain_len; pend_dd = done_in_drain;
    end else if (aif.adc_start) conv_left = conv_len;
    else if (conv_left > 0) begin
      conv_left--;
      if (conv_left == 0) begin
        aif.adc_done = 1;
        if (data_q.size() > 0) aif.adc_data = DATA_W'(data_q.pop_front());
        else aif.adc_data = DATA_W'($urandom_range(0, 4095));
        done_t.push_back(ncyc);
      end
    end else if (drain_left > 0) begin
      drain_left--;
      if (pend_dd) begin aif.adc_done = 1; aif.adc_data = 12'hABC; pend_dd = 0; end
    end
    aif.adc_busy = (conv_left > 0) || (drain_left > 0);
  endtask

  task automatic wait_starts(input int n, input int lim);
    int k = 0;
    while (n_starts < n && k < lim) begin step(); k++; end
    cmp("wait_starts", n_starts, n);
  endtask

  task automatic wait_idle(input int lim);
    int k = 0;
    while (busy && k < lim) begin step(); k++; end
    cmp("wait_idle", busy, 0);
  endtask

  task automatic wait_done(input int lim);
    int k = 0;
    while (!aif.adc_done && k < lim) begin step(); k++; end
    cmp("wait_done", aif.adc_done, 1);
  endtask

  task automatic pop_all();
    for (int i = 0; i < DEPTH + 2; i++) begin rd_en = 1; step(); end
    cmp("fifo_drained", fifo_count, 0);
  endtask

  initial begin
    aif.adc_busy = 0; aif.adc_done = 0; aif.adc_data = '0;
    repeat (3) step();
    reset = 0;
    step();
    cmp("rst_busy", busy, 0);          cmp("rst_count", fifo_count, 0);
    cmp("rst_irq", irq, 0);            cmp("rst_rd_data", rd_data, 0);
    cmp("rst_overrun", overrun, 0);    cmp("rst_adc_start", aif.adc_start, 0);

    // start while disabled is ignored
    n_starts = 0; cmd_start = 1;
    repeat (5) step();
    cmp("start_disabled", n_starts, 0);
    cfg_enable = 1; step();

    // single shot
    cfg_mode = 0; cfg_period = 100; conv_len = 40; data_q = {2500};
    n_starts = 0; cmd_start = 1;
    repeat (60) step();
    cmp("single_starts", n_starts, 1);  cmp("single_count", fifo_count, 1);
    cmp("single_data", rd_data, 2500);  cmp("single_irq", irq, 1);
    cmp("single_busy", busy, 0);
    pop_all();

    // periodic
    cfg_mode = 1; cfg_period = 200; conv_len = 40; data_q = {1000, 2000, 3000};
    n_starts = 0; start_t.delete(); cmd_start = 1;
    wait_starts(3, 1000);
    repeat (50) step();
    cmd_abort = 1; step();
    wait_idle(50);
    if (start_t.size() >= 3) begin
      cmp("auto_period_1", start_t[1] - start_t[0], 200);
      cmp("auto_period_2", start_t[2] - start_t[1], 200);
    end
    cmp("auto_count", fifo_count, 3);
    cmp("auto_d0", rd_data, 1000); rd_en = 1; step();
    cmp("auto_d1", rd_data, 2000); rd_en = 1; step();
    cmp("auto_d2", rd_data, 3000); rd_en = 1; step();
    cmp("auto_empty", fifo_count, 0);

    // overlong conversion, ended by disable
    cfg_period = 20; conv_len = 50; n_starts = 0; start_t.delete(); done_t.delete();
    cmd_start = 1;
    wait_starts(3, 500);
    cfg_enable = 0; step();
    wait_idle(20);
    cfg_enable = 1;
    if (start_t.size() >= 3 && done_t.size() >= 2) begin
      cmp("overlong_1", start_t[1], done_t[0] + 1);
      cmp("overlong_2", start_t[2], done_t[1] + 1);
      cmp("overlong_gap", start_t[1] - start_t[0], 51);
    end
    pop_all();

    // abort during CONV, done arriving in DRAIN is discarded
    cfg_period = 200; conv_len = 40; done_in_drain = 1; drain_len = 3;
    n_aborts = 0; cmd_start = 1;
    repeat (10) step();
    cmd_abort = 1; step();
    cmp("abort_pulse", aif.adc_abort, 1);
    step();
    cmp("abort_one_cycle", aif.adc_abort, 0);
    wait_idle(20);
    cmp("abort_count", n_aborts, 1);   cmp("abort_no_push", fifo_count, 0);
    // same via enable falling edge
    n_aborts = 0; cmd_start = 1;
    repeat (10) step();
    cfg_enable = 0; step();
    cmp("dis_pulse", aif.adc_abort, 1);
    step();
    wait_idle(20);
    cfg_enable = 1;
    cmp("dis_count", n_aborts, 1);     cmp("dis_no_push", fifo_count, 0);
    // abort in the same cycle as done
    conv_len = 10; done_in_drain = 0; drain_len = 1; cmd_start = 1;
    wait_done(30);
    cmd_abort = 1; step();
    wait_idle(20);
    cmp("abort_with_done", fifo_count, 0);

    // overrun
    cfg_period = 20; conv_len = 5; data_q = {11, 12, 13, 14, 15, 16};
    n_starts = 0; cmd_start = 1;
    wait_starts(6, 500);
    repeat (10) step();
    cmd_abort = 1; step();
    wait_idle(20);
    cmp("ovr_count", fifo_count, 4);   cmp("ovr_flag", overrun, 1);
    cmp("ovr_head", rd_data, 11);
    clr_overrun = 1; step();
    cmp("ovr_clear", overrun, 0);
    cfg_mode = 0; data_q = {17}; cmd_start = 1;
    wait_done(30);
    rd_en = 1; step();
    cmp("full_pushpop_count", fifo_count, 4);
    cmp("full_pushpop_ovr", overrun, 0);
    cmp("full_pushpop_head", rd_data, 12);
    step(); data_q = {18}; cmd_start = 1;
    wait_done(30); step();
    cmp("ovr_again", overrun, 1);      cmp("ovr_again_count", fifo_count, 4);
    step(); data_q = {19}; cmd_start = 1;
    wait_done(30);
    clr_overrun = 1; step();
    cmp("ovr_set_wins", overrun, 1);
    clr_overrun = 1; step();
    cmp("ovr_cleared", overrun, 0);
    pop_all();

    // reset in WAIT with two entries buffered
    cfg_mode = 1; cfg_period = 200; conv_len = 10; n_starts = 0; cmd_start = 1;
    wait_starts(2, 500);
    repeat (20) step();
    cmp("pre_reset_count", fifo_count, 2);
    reset = 1; step(); reset = 0;
    cmp("mid_rst_count", fifo_count, 0); cmp("mid_rst_irq", irq, 0);
    cmp("mid_rst_busy", busy, 0);        cmp("mid_rst_abort", aif.adc_abort, 0);
    n_starts = 0; n_aborts = 0;
    repeat (300) step();
    cmp("post_rst_starts", n_starts, 0); cmp("post_rst_aborts", n_aborts, 0);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      step();
      if (!busy && $urandom_range(0, 19) == 0) cfg_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) cfg_enable = ~cfg_enable;
      if ($urandom_range(0, 49) == 0) cfg_period = DIV_W'($urandom_range(0, 40));
      cmd_start   = ($urandom_range(0, 9) == 0);
      cmd_abort   = ($urandom_range(0, 199) == 0);
      rd_en       = ($urandom_range(0, 3) == 0);
      clr_overrun = ($urandom_range(0, 29) == 0);
      if (!aif.adc_busy) begin
        conv_len      = $urandom_range(1, 45);
        drain_len     = $urandom_range(0, 3);
        done_in_drain = 1'($urandom_range(0, 1));
      end
    end
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
